ahb_sram_slave: RTL and testbench

Synthesisable AHB slave backed by a byte-addressable word memory, with a fixed, parameterised wait-state count and a two-cycle ERROR response for illegal transfers. It answers the file-driven bus master across the same AHB interconnect, sits behind the system address decoder on one HSEL line, and is the first non-behavioural slave target for directed command scripts.

---
 rtl/ahb_pkg.sv | 42 ++++
 rtl/ahb_sram_slave_mem.sv | 30 +++
 rtl/ahb_sram_slave.sv | 118 +++++++++++
 tb/tb_ahb_sram_slave.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer-type, response and size encodings, plus
// helpers that turn HSIZE and the low address bits into byte-lane enables
// and a legality flag.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Little-endian lanes: byte k of the word lives on data bits [8k+7:8k].
  function automatic logic [3:0] lane_enable(input logic [2:0] size,
                                             input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: lane_enable = 4'b0001 << addr;
      HSIZE_HALF: lane_enable = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_enable = 4'b1111;
      default:    lane_enable = 4'b0000;
    endcase
  endfunction

  // Sizes above a word, and halfwords/words not naturally aligned.
  function automatic logic size_illegal(input logic [2:0] size,
                                        input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: size_illegal = 1'b0;
      HSIZE_HALF: size_illegal = addr[0];
      HSIZE_WORD: size_illegal = (addr != 2'b00);
      default:    size_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised memory with per-byte write enables.
// Ports: clk; we + be (byte enables) + addr (word index) + wdata write on the
// rising edge; rdata returns the word at addr combinationally.
// Contents are never reset.
module ahb_sram_slave_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-3:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave in front of a byte-addressable SRAM model.
// Ports: HCLK/HRESETn (sync, active-low); AHB address-phase inputs HSEL,
// HADDR, HTRANS, HWRITE, HSIZE, HBURST (ignored); HWDATA in the data phase;
// HREADY bus ready in. Outputs HRDATA, HREADYOUT, HRESP (OKAY/ERROR only).
// Every legal beat sees WAIT_STATES wait cycles then one DATA cycle; illegal
// beats get the two-cycle ERROR response and never touch memory.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              wait_cnt, wait_cnt_nxt;
  logic                    load;
  logic                    accept;
  logic                    illegal;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic                    write_p0;
  logic [2:0]              size_p0;
  logic                    mem_we;
  logic [31:0]             mem_rdata;
  logic                    unused_ok;

  // Beats are handled independently, so burst type and the undecoded upper
  // address bits carry no information here.
  assign unused_ok = ^{HBURST, HADDR[31:ADDR_WIDTH]};

  assign accept  = HSEL && HREADY && HTRANS[1];
  assign illegal = size_illegal(HSIZE, HADDR[1:0]);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    load         = 1'b0;
    case (state)
      ST_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = ST_DATA;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end with HREADYOUT=1, so a new address
        // phase can be taken here.
        if (accept) begin
          load = 1'b1;
          if (illegal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 4'(WAIT_STATES - 1);
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // ---- address phase -> data phase boundary ----
  always_ff @(posedge HCLK) begin
    if (load) begin
      addr_p0  <= HADDR[ADDR_WIDTH-1:0];
      write_p0 <= HWRITE;
      size_p0  <= HSIZE;
    end
  end

  // Gating on HRESETn drops a write whose closing edge coincides with reset.
  assign mem_we = (state == ST_DATA) && write_p0 && HRESETn;

  ahb_sram_slave_mem #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (HCLK),
    .we   (mem_we),
    .be   (lane_enable(size_p0, addr_p0[1:0])),
    .addr (addr_p0[ADDR_WIDTH-1:2]),
    .wdata(HWDATA),
    .rdata(mem_rdata)
  );

  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = ((state == ST_DATA) && !write_p0) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with no wait states and one
// with three, sharing the bus signals; dut_sel routes HSEL and the bus HREADY.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, hsel, hwrite, dut_sel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;

  logic [31:0] rd0, rd3, hrdata;
  logic        ro0, ro3, hready;
  logic [1:0]  rs0, rs3, hresp;
  logic        sel0, sel3;

  assign sel0   = hsel & ~dut_sel;
  assign sel3   = hsel & dut_sel;
  assign hready = dut_sel ? ro3 : ro0;
  assign hrdata = dut_sel ? rd3 : rd0;
  assign hresp  = dut_sel ? rs3 : rs0;

  ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
  );

  ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready), .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
    hburst = 3'b000;
  endtask

  // One NONSEQ beat followed by an idle bus. Entered and left at 1 time unit
  // after a rising edge; the last edge consumed is the one closing the beat.
  task automatic xfer(input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int waits,
                      output logic [1:0] wresp, output logic [1:0] resp);
    logic done;
    done = 1'b0; waits = 0; wresp = 2'b00; rdata = 32'h0; resp = 2'b00;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr;
    hsize = size; hburst = 3'b000;
    @(posedge clk); #1;
    idle_bus();
    hwdata = wdata;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (hready) begin
        done  = 1'b1;
        rdata = hrdata;
        resp  = hresp;
      end else begin
        waits++;
        wresp = hresp;
      end
      @(posedge clk); #1;
    end
    if (!done) check_val("xfer_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  int          nw;
  logic [1:0]  wrsp, rsp;

  // Burst with BUSY cycles: per-cycle HTRANS, HADDR and the HWDATA of the
  // beat whose data phase is in that cycle.
  logic [1:0]  tr_tab [7] = '{HTRANS_NONSEQ, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ,
                              HTRANS_BUSY, HTRANS_SEQ, HTRANS_IDLE};
  logic [31:0] ad_tab [7] = '{32'h020, 32'h024, 32'h024, 32'h028,
                              32'h02C, 32'h02C, 32'h02C};
  logic [31:0] wd_tab [7] = '{32'h0, 32'hA0A0_0001, 32'h0, 32'hB1B1_0002,
                              32'hC2C2_0003, 32'h0, 32'hD3D3_0004};
  logic [31:0] bexp   [4] = '{32'hA0A0_0001, 32'hB1B1_0002,
                              32'hC2C2_0003, 32'hD3D3_0004};

  initial begin
    rstn = 1'b0; dut_sel = 1'b0; haddr = 32'h0; hwdata = 32'h0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      dut_sel = s[0];
      @(negedge clk);
      check_val("rst_readyout", {31'h0, hready}, 32'h1);
      check_val("rst_resp", {30'h0, hresp}, 32'h0);
      check_val("rst_rdata", hrdata, 32'h0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;

    // Zero-wait write then pipelined read of the same word
    dut_sel = 1'b0;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h010; hwrite = 1'b1;
    hsize = HSIZE_WORD;
    @(negedge clk);
    check_val("ws0_addr_rdy", {31'h0, hready}, 32'h1);
    @(posedge clk); #1;
    hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
    @(negedge clk);
    check_val("ws0_wdata_rdy", {31'h0, hready}, 32'h1);
    check_val("ws0_wdata_resp", {30'h0, hresp}, 32'h0);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check_val("ws0_rdata_rdy", {31'h0, hready}, 32'h1);
    check_val("ws0_rdata_resp", {30'h0, hresp}, 32'h0);
    check_val("ws0_rdata", hrdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("ws0_idle_rdata", hrdata, 32'h0);
    @(posedge clk); #1;

    // Three wait states on the second instance
    dut_sel = 1'b1;
    xfer(32'h010, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, rd, nw, wrsp, rsp);
    check_val("ws3_wr_waits", nw, 32'd3);
    xfer(32'h010, 1'b0, HSIZE_WORD, 32'h0, rd, nw, wrsp, rsp);
    check_val("ws3_rd_waits", nw, 32'd3);
    check_val("ws3_rd_resp", {30'h0, rsp}, 32'h0);
    check_val("ws3_rd_data", rd, 32'hDEAD_BEEF);

    // Byte and halfword lanes
    xfer(32'h012, 1'b1, HSIZE_BYTE, 32'h0055_0000, rd, nw, wrsp, rsp);
    xfer(32'h010, 1'b0, HSIZE_WORD, 32'h0, rd, nw, wrsp, rsp);
    check_val("byte_lane2", rd, 32'hDE55_BEEF);
    xfer(32'h014, 1'b1, HSIZE_WORD, 32'h1122_3344, rd, nw, wrsp, rsp);
    xfer(32'h016, 1'b1, HSIZE_HALF, 32'hABCD_0000, rd, nw, wrsp, rsp);
    xfer(32'h014, 1'b0, HSIZE_WORD, 32'h0, rd, nw, wrsp, rsp);
    check_val("half_upper", rd, 32'hABCD_3344);

    // Illegal transfers: misaligned word read, size 011, misaligned write
    xfer(32'h013, 1'b0, HSIZE_WORD, 32'h0, rd, nw, wrsp, rsp);
    check_val("err_mis_err1_cycles", nw, 32'd1);
    check_val("err_mis_err1_resp", {30'h0, wrsp}, 32'h1);
    check_val("err_mis_err2_resp", {30'h0, rsp}, 32'h1);
    @(negedge clk);
    check_val("err_mis_after_rdy", {31'h0, hready}, 32'h1);
    check_val("err_mis_after_resp", {30'h0, hresp}, 32'h0);
    @(posedge clk); #1;
    xfer(32'h010, 1'b0, 3'b011, 32'h0, rd, nw, wrsp, rsp);
    check_val("err_size_err1_cycles", nw, 32'd1);
    check_val("err_size_err1_resp", {30'h0, wrsp}, 32'h1);
    check_val("err_size_err2_resp", {30'h0, rsp}, 32'h1);
    @(negedge clk);
    check_val("err_size_after_resp", {30'h0, hresp}, 32'h0);
    @(posedge clk); #1;
    xfer(32'h012, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, rd, nw, wrsp, rsp);
    check_val("err_wr_resp", {30'h0, rsp}, 32'h1);
    xfer(32'h010, 1'b0, HSIZE_WORD, 32'h0, rd, nw, wrsp, rsp);
    check_val("err_mem_unchanged", rd, 32'hDE55_BEEF);

    // Four-beat INCR burst with BUSY and IDLE cycles, zero-wait instance
    dut_sel = 1'b0;
    for (int i = 0; i < 7; i++) begin
      hsel = 1'b1; htrans = tr_tab[i]; haddr = ad_tab[i]; hwrite = 1'b1;
      hsize = HSIZE_WORD; hburst = 3'b001; hwdata = wd_tab[i];
      @(negedge clk);
      check_val($sformatf("burst_rdy_c%0d", i), {31'h0, hready}, 32'h1);
      check_val($sformatf("burst_resp_c%0d", i), {30'h0, hresp}, 32'h0);
      @(posedge clk); #1;
    end
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      xfer(32'h020 + 32'(4 * i), 1'b0, HSIZE_WORD, 32'h0, rd, nw, wrsp, rsp);
      check_val($sformatf("burst_word%0d", i), rd, bexp[i]);
    end

    // Reset during a wait state of a write discards it
    dut_sel = 1'b1;
    xfer(32'h030, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, rd, nw, wrsp, rsp);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h030; hwrite = 1'b1;
    hsize = HSIZE_WORD;
    @(posedge clk); #1;
    idle_bus();
    hwdata = 32'h1234_5678;
    @(negedge clk);
    check_val("rstw_in_wait", {31'h0, hready}, 32'h0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_val("rstw_rdy", {31'h0, hready}, 32'h1);
    check_val("rstw_resp", {30'h0, hresp}, 32'h0);
    check_val("rstw_rdata", hrdata, 32'h0);
    @(posedge clk); #1;
    xfer(32'h030, 1'b0, HSIZE_WORD, 32'h0, rd, nw, wrsp, rsp);
    check_val("rstw_mem_kept", rd, 32'hCAFE_F00D);
    check_val("rstw_next_waits", nw, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
